// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
// Per-frame sprite controller feeding the palette-ROM sprite renderer.
// Moves the sprite in a bouncing diagonal and runs a timed "pop" animation
// (alternate image for POP_FRAMES frames, then a COOLDOWN_FRAMES lockout).
// All outputs update only on the edge that ends the frame-tick cycle
// (hcount == 0, vcount == SCREEN_H). This keeps the renderer's view constant
// for the whole active region.
//
// Ports
//   pixel_clk_in   : single clock, rising edge
//   rst_in         : asynchronous active-low reset
//   hcount_in[10:0]: current pixel column
//   vcount_in[9:0] : current line
//   move_en_in     : move the sprite at each frame tick when high
//   pop_req_in     : single-cycle pop request
//   x_out[10:0]    : sprite left edge
//   y_out[9:0]     : sprite top edge
//   pop_out        : 1 = base image, 0 = popped image
//   frame_tick_out : one-cycle pulse coincident with every output update
module sprite_motion_ctrl #(
  parameter int SCREEN_W        = 1280,
  parameter int SCREEN_H        = 720,
  parameter int SPRITE_W        = 256,
  parameter int SPRITE_H        = 256,
  parameter int SPEED_X         = 2,
  parameter int SPEED_Y         = 1,
  parameter int POP_FRAMES      = 30,
  parameter int COOLDOWN_FRAMES = 60
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        move_en_in,
  input  logic        pop_req_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        pop_out,
  output logic        frame_tick_out
);

  localparam int XMAX    = SCREEN_W - SPRITE_W;
  localparam int YMAX    = SCREEN_H - SPRITE_H;
  localparam int CNT_MAX = (POP_FRAMES > COOLDOWN_FRAMES) ? POP_FRAMES : COOLDOWN_FRAMES;
  // The counter only ever holds values up to CNT_MAX-1.
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    POPPED   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic            pending_r;
  logic [10:0]     x_r;
  logic [9:0]      y_r;
  logic            dir_x_r;
  logic            dir_y_r;
  logic            pop_r;
  logic            tick_r;

  logic            tick_s;
  logic            move_s;
  logic [11:0]     x_sum_s;
  logic [10:0]     y_sum_s;
  logic [10:0]     x_nxt_s;
  logic [9:0]      y_nxt_s;
  logic            dir_x_nxt_s;
  logic            dir_y_nxt_s;

  assign tick_s = (hcount_in == 11'd0) && (vcount_in == 10'(SCREEN_H));
  // Movement is frozen for every tick that starts in POPPED, including the
  // tick that leaves it.
  assign move_s = move_en_in && (state_r != POPPED);

  // Next X position and direction. The sum is one bit wider so it cannot wrap.
  always_comb begin
    x_sum_s     = {1'b0, x_r} + 12'(SPEED_X);
    x_nxt_s     = x_r;
    dir_x_nxt_s = dir_x_r;
    if (dir_x_r && (x_sum_s >= 12'(XMAX))) begin
      x_nxt_s     = 11'(XMAX);
      dir_x_nxt_s = 1'b0;
    end else if (dir_x_r) begin
      x_nxt_s     = x_sum_s[10:0];
      dir_x_nxt_s = 1'b1;
    end else if (x_r <= 11'(SPEED_X)) begin
      x_nxt_s     = 11'd0;
      dir_x_nxt_s = 1'b1;
    end else begin
      x_nxt_s     = x_r - 11'(SPEED_X);
      dir_x_nxt_s = 1'b0;
    end
  end

  // Next Y position and direction, same rule as X.
  always_comb begin
    y_sum_s     = {1'b0, y_r} + 11'(SPEED_Y);
    y_nxt_s     = y_r;
    dir_y_nxt_s = dir_y_r;
    if (dir_y_r && (y_sum_s >= 11'(YMAX))) begin
      y_nxt_s     = 10'(YMAX);
      dir_y_nxt_s = 1'b0;
    end else if (dir_y_r) begin
      y_nxt_s     = y_sum_s[9:0];
      dir_y_nxt_s = 1'b1;
    end else if (y_r <= 10'(SPEED_Y)) begin
      y_nxt_s     = 10'd0;
      dir_y_nxt_s = 1'b1;
    end else begin
      y_nxt_s     = y_r - 10'(SPEED_Y);
      dir_y_nxt_s = 1'b0;
    end
  end

  // Position, pop FSM, pending flag and tick pulse, all advanced at the frame tick.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      pending_r <= 1'b0;
      x_r       <= 11'd0;
      y_r       <= 10'd0;
      dir_x_r   <= 1'b1;
      dir_y_r   <= 1'b1;
      pop_r     <= 1'b1;
      tick_r    <= 1'b0;
    end else begin
      tick_r <= tick_s;
      if (tick_s) begin
        if (move_s) begin
          x_r     <= x_nxt_s;
          y_r     <= y_nxt_s;
          dir_x_r <= dir_x_nxt_s;
          dir_y_r <= dir_y_nxt_s;
        end
        case (state_r)
          IDLE: begin
            // A request in the tick cycle itself is honoured at this tick.
            if (pending_r || pop_req_in) begin
              state_r   <= POPPED;
              pop_r     <= 1'b0;
              cnt_r     <= CW'(POP_FRAMES - 1);
              pending_r <= 1'b0;
            end
          end
          POPPED: begin
            pending_r <= 1'b0;
            if (cnt_r == '0) begin
              state_r <= COOLDOWN;
              pop_r   <= 1'b1;
              cnt_r   <= CW'(COOLDOWN_FRAMES - 1);
            end else begin
              cnt_r <= cnt_r - CW'(1);
            end
          end
          COOLDOWN: begin
            pending_r <= 1'b0;
            if (cnt_r == '0) begin
              state_r <= IDLE;
            end else begin
              cnt_r <= cnt_r - CW'(1);
            end
          end
          default: begin
            state_r   <= IDLE;
            pop_r     <= 1'b1;
            cnt_r     <= '0;
            pending_r <= 1'b0;
          end
        endcase
      end else if ((state_r == IDLE) && pop_req_in) begin
        // Requests outside the tick are remembered only while idle.
        pending_r <= 1'b1;
      end
    end
  end

  assign x_out          = x_r;
  assign y_out          = y_r;
  assign pop_out        = pop_r;
  assign frame_tick_out = tick_r;

endmodule
